// File: rtl/imm_li_expand_if.sv
// Request/instruction handshake bundle for imm_li_expand.
// The slave modport is the expander's view; master is the source/sink environment.
interface imm_li_expand_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_rd;
   logic [31:0] req_value;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins;
   logic        ins_last;

   modport master (
      output req_valid, req_rd, req_value, ins_ready,
      input  req_ready, ins_valid, ins, ins_last
   );

   modport slave (
      input  req_valid, req_rd, req_value, ins_ready,
      output req_ready, ins_valid, ins, ins_last
   );
endinterface

// File: rtl/imm_li_expand.sv
// Expands a 32-bit constant into RV32I LUI/ADDI instruction words for register rd.
// One request in flight at a time; words are presented on a registered valid/ready output.
module imm_li_expand #(
   parameter bit ZERO_RD_NOP = 1'b1
) (
   input logic           clk,
   input logic           rst,
   imm_li_expand_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      EMIT_FIRST  = 2'd1,
      EMIT_SECOND = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  rd_q;
   logic [11:0] lo_q;
   logic [31:0] ins_q;
   logic        last_q;
   logic        valid_q;

   logic [19:0] hi_in;
   logic [11:0] lo_in;
   logic        nop_in;
   logic        single_in;
   logic [31:0] first_in;
   logic [31:0] second_word;

   // The +value[11] carry compensates for ADDI sign-extending its 12-bit immediate.
   always_comb begin
      hi_in     = bus.req_value[31:12] + {19'd0, bus.req_value[11]};
      lo_in     = bus.req_value[11:0];
      nop_in    = ZERO_RD_NOP && (bus.req_rd == 5'd0);
      single_in = nop_in || (hi_in == 20'd0) || (lo_in == 12'd0);
      if (nop_in)
         first_in = 32'h0000_0013;
      else if (hi_in == 20'd0)
         first_in = {lo_in, 5'd0, 3'b000, bus.req_rd, 7'b0010011};
      else
         first_in = {hi_in, bus.req_rd, 7'b0110111};
   end

   assign second_word   = {lo_q, rd_q, 3'b000, rd_q, 7'b0010011};
   assign bus.req_ready = (state == IDLE);
   assign bus.ins_valid = valid_q;
   assign bus.ins       = ins_q;
   assign bus.ins_last  = last_q;

   // In EMIT_FIRST, last_q low means an ADDI still has to follow the LUI.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd_q    <= 5'd0;
         lo_q    <= 12'd0;
         ins_q   <= 32'd0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  rd_q    <= bus.req_rd;
                  lo_q    <= lo_in;
                  ins_q   <= first_in;
                  last_q  <= single_in;
                  valid_q <= 1'b1;
                  state   <= EMIT_FIRST;
               end
            end
            EMIT_FIRST: begin
               if (bus.ins_ready) begin
                  if (!last_q) begin
                     ins_q  <= second_word;
                     last_q <= 1'b1;
                     state  <= EMIT_SECOND;
                  end else begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            EMIT_SECOND: begin
               if (bus.ins_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imm_li_expand.sv
// Scoreboard bench for imm_li_expand: two instances cover both rd=0 behaviours.
// Stimulus pushes expected words; per-instance monitors pop and compare on each transfer.
module tb_imm_li_expand;
   logic clk;
   logic rst;

   imm_li_expand_if if_a ();
   imm_li_expand_if if_b ();

   imm_li_expand #(.ZERO_RD_NOP(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   imm_li_expand #(.ZERO_RD_NOP(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

   typedef struct packed {
      logic [31:0] word;
      logic        last;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected)
         n_pass++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Transfers are sampled on the falling edge, half a cycle before the edge that commits them.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && if_a.ins_valid && if_a.ins_ready) begin
         if (exp_a.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL a_unexpected: got 0x%08h, expected no word", if_a.ins);
         end else begin
            e = exp_a.pop_front();
            checkOutput("a_ins", if_a.ins, e.word);
            checkOutput("a_last", {31'd0, if_a.ins_last}, {31'd0, e.last});
         end
      end
      if (!rst && if_b.ins_valid && if_b.ins_ready) begin
         if (exp_b.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL b_unexpected: got 0x%08h, expected no word", if_b.ins);
         end else begin
            e = exp_b.pop_front();
            checkOutput("b_ins", if_b.ins, e.word);
            checkOutput("b_last", {31'd0, if_b.ins_last}, {31'd0, e.last});
         end
      end
   end

   task automatic pushExp(input bit use_b, input logic [31:0] word, input logic last);
      exp_t e;
      e.word = word;
      e.last = last;
      if (use_b) exp_b.push_back(e);
      else       exp_a.push_back(e);
   endtask

   // Returns 1 ns after the edge at which the request was accepted.
   task automatic applyStimulus(input bit use_b, input logic [4:0] rd, input logic [31:0] value,
                                input int nwords, input logic [31:0] w0, input logic [31:0] w1);
      bit accepted = 1'b0;
      if (nwords == 1) begin
         pushExp(use_b, w0, 1'b1);
      end else begin
         pushExp(use_b, w0, 1'b0);
         pushExp(use_b, w1, 1'b1);
      end
      if (use_b) begin
         if_b.req_valid = 1'b1; if_b.req_rd = rd; if_b.req_value = value;
      end else begin
         if_a.req_valid = 1'b1; if_a.req_rd = rd; if_a.req_value = value;
      end
      for (int i = 0; i < 50 && !accepted; i++) begin
         accepted = use_b ? if_b.req_ready : if_a.req_ready;
         @(posedge clk);
         #1;
      end
      if_a.req_valid = 1'b0;
      if_b.req_valid = 1'b0;
      if (!accepted) begin
         n_checks++;
         $display("[TB] FAIL accept_timeout: got no accept, expected accept within 50 cycles");
      end
   endtask

   task automatic waitIdle(input bit use_b);
      bit done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         if (use_b) done = (exp_b.size() == 0) && if_b.req_ready;
         else       done = (exp_a.size() == 0) && if_a.req_ready;
         if (!done) begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) begin
         n_checks++;
         $display("[TB] FAIL idle_timeout: got expansion still pending, expected idle within 50 cycles");
      end
   endtask

   initial begin
      if_a.req_valid = 1'b0; if_a.req_rd = 5'd0; if_a.req_value = 32'd0; if_a.ins_ready = 1'b1;
      if_b.req_valid = 1'b0; if_b.req_rd = 5'd0; if_b.req_value = 32'd0; if_b.ins_ready = 1'b1;
      rst = 1'b1;
      #1;
      checkOutput("rst_req_ready", {31'd0, if_a.req_ready}, 32'd1);
      checkOutput("rst_ins_valid", {31'd0, if_a.ins_valid}, 32'd0);
      checkOutput("rst_ins_last", {31'd0, if_a.ins_last}, 32'd0);
      checkOutput("rst_ins", if_a.ins, 32'd0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Two-word expansion with latency / ready-return checks.
      applyStimulus(0, 5'd5, 32'h12345678, 2, 32'h123452B7, 32'h67828293);
      checkOutput("lat_valid", {31'd0, if_a.ins_valid}, 32'd1);
      checkOutput("lat_busy", {31'd0, if_a.req_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_second_valid", {31'd0, if_a.ins_valid}, 32'd1);
      @(posedge clk); #1;
      checkOutput("ready_after_last", {31'd0, if_a.req_ready}, 32'd1);
      checkOutput("valid_after_last", {31'd0, if_a.ins_valid}, 32'd0);
      waitIdle(0);

      applyStimulus(0, 5'd10, 32'h12345FFF, 2, 32'h12346537, 32'hFFF50513); waitIdle(0);
      applyStimulus(0, 5'd1,  32'hFFFFF800, 1, 32'h80000093, 32'd0);      waitIdle(0);
      applyStimulus(0, 5'd2,  32'h00001000, 1, 32'h00001137, 32'd0);      waitIdle(0);
      applyStimulus(0, 5'd3,  32'h00000000, 1, 32'h00000193, 32'd0);      waitIdle(0);
      applyStimulus(0, 5'd0,  32'h12345678, 1, 32'h00000013, 32'd0);      waitIdle(0);
      applyStimulus(1, 5'd0,  32'h12345678, 2, 32'h12345037, 32'h67800013); waitIdle(1);

      // Backpressure: three stalled cycles per word, with an ignored request pulse.
      if_a.ins_ready = 1'b0;
      applyStimulus(0, 5'd5, 32'h12345678, 2, 32'h123452B7, 32'h67828293);
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall1_ins", if_a.ins, 32'h123452B7);
         checkOutput("stall1_ready", {31'd0, if_a.req_ready}, 32'd0);
         if (i == 1) begin
            if_a.req_valid = 1'b1; if_a.req_rd = 5'd3; if_a.req_value = 32'd0;
         end
         @(posedge clk); #1;
         if_a.req_valid = 1'b0;
      end
      if_a.ins_ready = 1'b1;
      @(posedge clk); #1;
      if_a.ins_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall2_ins", if_a.ins, 32'h67828293);
         checkOutput("stall2_last", {31'd0, if_a.ins_last}, 32'd1);
         checkOutput("stall2_ready", {31'd0, if_a.req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      if_a.ins_ready = 1'b1;
      waitIdle(0);

      // Reset while the ADDI of a two-word expansion is waiting.
      if_a.ins_ready = 1'b0;
      applyStimulus(0, 5'd5, 32'h12345678, 2, 32'h123452B7, 32'h67828293);
      if_a.ins_ready = 1'b1;
      @(posedge clk); #1;
      if_a.ins_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("pre_rst_ins", if_a.ins, 32'h67828293);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", {31'd0, if_a.ins_valid}, 32'd0);
      checkOutput("mid_rst_ins", if_a.ins, 32'd0);
      checkOutput("mid_rst_ready", {31'd0, if_a.req_ready}, 32'd1);
      exp_a.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      if_a.ins_ready = 1'b1;
      applyStimulus(0, 5'd2, 32'h00001000, 1, 32'h00001137, 32'd0);
      waitIdle(0);
      repeat (3) @(posedge clk);
      #1;

      checkOutput("a_drained", exp_a.size(), 32'd0);
      checkOutput("b_drained", exp_b.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/imm_li_expand.md
# imm_li_expand

Materialises a 32-bit constant into a destination register by emitting RV32I instruction words. It is the encoder counterpart of the immediate decode path: it splits a constant into U-type (LUI) and I-type (ADDI) immediate fields and packs them into instruction bits. The block sits between a constant/pseudo-op source (test sequencer, boot ROM builder, or `li` expansion in the fetch front end) and an instruction sink, with valid/ready handshakes on both sides.

## Interface

Parameters:
- `ZERO_RD_NOP`, default 1: if 1, a request with `rd`=0 emits the single canonical NOP 0x00000013; if 0, it is expanded like any other `rd`.

Ports:
- `clk`  in  1  clock, all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_rd`  in  5  destination register index.
- `req_value`  in  32  constant to materialise.
- `ins_valid`  out  1  `ins` holds a valid instruction.
- `ins_ready`  in  1  sink accepts `ins` this cycle.
- `ins`  out  32  encoded instruction word, registered.
- `ins_last`  out  1  `ins` is the final word of the current expansion.

## Operation

- Request accepted on a cycle with `req_valid && req_ready`; `rd` and `value` are captured into registers.
- Split, all modulo 2^20 / 2^12:
  - `lo = value[11:0]`, treated as a signed 12-bit value.
  - `hi = value[31:12] + value[11]`, 20 bits, wrap-around discarded (`value[31:12]`=0xFFFFF with `value[11]`=1 gives `hi`=0).
- Expansion selection, in priority order:
  - `rd`=0 and `ZERO_RD_NOP`=1: one word, 0x00000013.
  - `hi`=0: one word, ADDI rd, x0, lo.
  - `lo`=0: one word, LUI rd, hi.
  - Otherwise: two words, LUI rd, hi, then ADDI rd, rd, lo.
- Encodings:
  - LUI = {hi, rd, 7'b0110111}.
  - ADDI = {lo, rs1, 3'b000, rd, 7'b0010011}.
- FSM states:
  - IDLE: `req_ready`=1, `ins_valid`=0. On accept, go to EMIT_FIRST with `ins` loaded.
  - EMIT_FIRST: `ins_valid`=1. On `ins_ready`, go to IDLE if single-word, else to EMIT_SECOND with the ADDI loaded.
  - EMIT_SECOND: `ins_valid`=1, `ins_last`=1. On `ins_ready`, go to IDLE.
- `req_ready` is high only in IDLE. There is no overlap of requests; `req_*` inputs are ignored outside IDLE.
- `ins` and `ins_last` are stable while `ins_valid && !ins_ready`.

## Timing

- Reset, asynchronous, takes effect immediately: state=IDLE, `req_ready`=1, `ins_valid`=0, `ins_last`=0, `ins`=0x00000000, captured `rd`/`value`=0.
- Reset during EMIT_FIRST/EMIT_SECOND drops the in-flight expansion; no partial word is emitted after reset.
- Latency:
  - Accept at edge N; first word valid after edge N, i.e. sampled by the sink at edge N+1 at the earliest.
  - With `ins_ready` held at 1: a single-word expansion occupies 1 output cycle and a two-word expansion 2 consecutive cycles. The next request can be accepted in the cycle after the last word is taken.
  - Throughput is 1 request per 2 cycles (single-word) or per 3 cycles (two-word).
- `req_ready` is combinational from state only, never from `req_valid` or `ins_ready`.
- The sink may hold `ins_ready` low indefinitely; the block waits with no timeout.

## Test plan

- `rd`=5, `value`=0x12345678, `ins_ready`=1 -> 0x123452B7 (`ins_last`=0), then 0x67828293 (`ins_last`=1); `req_ready` returns to 1 the next cycle.
- `rd`=10, `value`=0x12345FFF (carry into `hi`) -> 0x12346537, then 0xFFF50513.
- Single-word cases:
  - `rd`=1, `value`=0xFFFFF800 (`hi` wraps to 0) -> 0x80000093 only.
  - `rd`=2, `value`=0x00001000 -> 0x00001137 only.
  - `rd`=3, `value`=0 -> 0x00000193 only.
  - `ins_last`=1 on each.
- `rd`=0, `value`=0x12345678 -> with `ZERO_RD_NOP`=1: 0x00000013 only. With `ZERO_RD_NOP`=0: 0x12345037 then 0x67800013.
- Backpressure on 0x12345678 / `rd`=5 with `ins_ready` low for 3 cycles in each word:
  - `ins` holds 0x123452B7, then 0x67828293, unchanged while stalled.
  - `req_ready` stays 0 throughout, and a `req_valid` pulse during the stall is not accepted.
- Assert `rst` mid-expansion, in EMIT_SECOND:
  - Outputs go immediately to `ins_valid`=0, `ins`=0, `req_ready`=1.
  - After release, a new request `rd`=2, `value`=0x1000 produces only 0x00001137.
